mem_bus_arbiter: RTL

- Shares the single system memory bus between the instruction-fetch refill path (I-side, read-only) and the data cache miss/write-back path (D-side, read/write).
- Each requester issues one burst of BURST_LEN word beats per request; the arbiter grants, sequences beat addresses and routes data and ready.
- D-side has fixed priority, guarded by a starvation limit so fetch cannot stall indefinitely.
- Sits between the instruction fetch logic, the dcache system-side port and the external memory model.

---
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Request/response and system-bus signals shared by the I-side, D-side and memory.
// The arbiter takes the master view; requesters and memory together take the slave view.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEAT_W = 2
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic [BEAT_W-1:0] d_beat;

  logic              sys_strobe;
  logic              sys_rw;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_wdata;
  logic [DATA_W-1:0] sys_rdata;
  logic              sys_ready;

  modport master (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, sys_rdata, sys_ready,
    output i_grant, i_ready, i_rdata, d_grant, d_ready, d_rdata, d_beat,
           sys_strobe, sys_rw, sys_addr, sys_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, sys_rdata, sys_ready,
    input  i_grant, i_ready, i_rdata, d_grant, d_ready, d_rdata, d_beat,
           sys_strobe, sys_rw, sys_addr, sys_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: D-side fixed priority with a starvation guard for I-side fetch,
// fixed-length bursts with per-beat address sequencing and ready/data routing.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  mem_bus_arbiter_if.master bus
);

  localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic                i_grant_q, i_grant_d;
  logic                d_grant_q, d_grant_d;
  logic                strobe_q, strobe_d;
  logic                rw_q,     rw_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                i_starved;

  assign i_starved = bus.i_req && (starve_q == STARVE_TOP);

  always_comb begin
    state_d   = state_q;
    i_grant_d = i_grant_q;
    d_grant_d = d_grant_q;
    strobe_d  = strobe_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    starve_d  = starve_q;

    unique case (state_q)
      IDLE: begin
        // Arbitration: D wins unless I has waited through STARVE_MAX D grants.
        if (bus.d_req && !i_starved) begin
          state_d   = GNT_D;
          d_grant_d = 1'b1;
          strobe_d  = 1'b1;
          rw_d      = bus.d_rw;
          addr_d    = bus.d_addr;
          beat_d    = '0;
          if (!bus.i_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (bus.i_req) begin
          state_d   = GNT_I;
          i_grant_d = 1'b1;
          strobe_d  = 1'b1;
          rw_d      = 1'b0;
          addr_d    = bus.i_addr;
          beat_d    = '0;
          starve_d  = '0;
        end
      end

      GNT_I, GNT_D: begin
        // Outputs hold through wait states; advance only on a completed beat.
        if (bus.sys_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            i_grant_d = 1'b0;
            d_grant_d = 1'b0;
            strobe_d  = 1'b0;
            rw_d      = 1'b0;
            addr_d    = '0;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            addr_d = addr_q + ADDR_W'(4);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
        strobe_d  = 1'b0;
        rw_d      = 1'b0;
        addr_d    = '0;
        beat_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      strobe_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      beat_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      strobe_q  <= strobe_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      starve_q  <= starve_d;
    end
  end

  // Ready and read data pass straight through, gated to the granted side only.
  assign bus.i_grant    = i_grant_q;
  assign bus.d_grant    = d_grant_q;
  assign bus.sys_strobe = strobe_q;
  assign bus.sys_rw     = rw_q;
  assign bus.sys_addr   = addr_q;
  assign bus.d_beat     = beat_q;
  assign bus.sys_wdata  = d_grant_q ? bus.d_wdata : '0;
  assign bus.i_ready    = i_grant_q & bus.sys_ready;
  assign bus.d_ready    = d_grant_q & bus.sys_ready;
  assign bus.i_rdata    = i_grant_q ? bus.sys_rdata : '0;
  assign bus.d_rdata    = d_grant_q ? bus.sys_rdata : '0;

endmodule
